// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle RV32 main control FSM.
// Holds the state encodings, ALUOp codes driven to the ALU-control decoder,
// the opcodes the FSM recognises and the ALUSrcB mux selects.
// Optional feature macro used by the top: ILLEGAL_TRAP_EN.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_TRAP   = 4'd9
  } state_e;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BRIMM = 2'b11;

  // States that hold a request on the unified memory and wait for MemReady.
  function automatic logic isMemState(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Memory wait counter with timeout compare for the multi-cycle control FSM.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   waiting_i  - FSM is in a memory-access state
//   ready_i    - memory completes the access this cycle
//   timeout_o  - wait limit reached with the access still outstanding
// MEM_TIMEOUT = 0 disables the timeout; the counter then only saturates.
module multicycle_control_mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Completion in the same cycle suppresses the timeout.
  assign timeout_o = (MEM_TIMEOUT != 0) && waiting_i && !ready_i && (cnt_q == TIMEOUT_VAL);

  // The FSM only leaves a memory state on ready or timeout, and every
  // non-memory state clears the count, so this also clears on state change.
  always_comb begin
    cnt_d = '0;
    if (waiting_i && !ready_i && !timeout_o) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32 datapath (R-type, lw, sw, beq).
// Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK, drives every datapath enable
// and produces the 2-bit ALUOp for the ALU-control decoder.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   opcode              - IR[6:0], used in DECODE and MEMADR
//   MemReady            - unified memory completes current access
//   ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite, PCWrite,
//   PCWriteCond, PCSource, RegWrite, MemtoReg - datapath controls
//   mem_err             - one-cycle pulse on memory timeout
//   state               - current state encoding, for debug
//   illegal             - only with ILLEGAL_TRAP_EN: high while trapped
// Macro ILLEGAL_TRAP_EN: unknown opcodes trap until reset instead of
// retiring as a NOP.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       MemReady,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCSource,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       mem_err,
  output logic [3:0] state
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  state_e state_q, state_d;
  logic   memTimeout;

  multicycle_control_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_mem_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .waiting_i(isMemState(state_q)),
    .ready_i  (MemReady),
    .timeout_o(memTimeout)
  );

  // Next-state logic. A timeout always returns to FETCH: in FETCH that is a
  // retry, in MEMRD/MEMWR it abandons the instruction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC;
          OP_BRANCH:         state_d = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (MemReady)        state_d = S_MEMWB;
        else if (memTimeout) state_d = S_FETCH;
      end
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (MemReady || memTimeout) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore decode of the state register; IRWrite/PCWrite in FETCH also wait
  // for the instruction word to arrive.
  always_comb begin
    ALUOp       = ALUOP_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RS2;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      S_DECODE: ALUSrcB = SRCB_BRIMM;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_RWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_err = memTimeout;
  assign state   = state_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal = (state_q == S_TRAP);
`endif

endmodule
